// File: rtl/alu_pkg.sv
// Shared types and encodings for the ALU issue/resolve block.
// The optional ALU result checker is enabled with the ALU_ISSUE_CHECK_EN macro.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    // ALU operation codes driven into the combinational ALU.
    // The code 5'b01000 is never issued.
    typedef enum logic [4:0] {
        ALU_NOP  = 5'b00000,
        ALU_ADD  = 5'b00001,
        ALU_SUB  = 5'b00010,
        ALU_ADDR = 5'b00011,
        ALU_AND  = 5'b00100,
        ALU_OR   = 5'b00101,
        ALU_LT   = 5'b00110,
        ALU_GE   = 5'b00111,
        ALU_XOR  = 5'b01001,
        ALU_EQ   = 5'b01010
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Operand source selects produced by the decoder.
    typedef enum logic [1:0] {
        A_RS1  = 2'd0,
        A_PC   = 2'd1,
        A_ZERO = 2'd2
    } a_sel_t;

    typedef enum logic {
        B_RS2 = 1'b0,
        B_IMM = 1'b1
    } b_sel_t;

    // RV32I major opcodes handled here.
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // funct3 values for arithmetic/logic.
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct3 values for branches.
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/alu_decoder.sv
// Combinational RV32I decode for the ALU issue path: maps an instruction word
// and its pc to an ALU op, operand selects, immediate, branch target and flags.
module alu_decoder
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output alu_op_t         op,
    output a_sel_t          a_sel,
    output b_sel_t          b_sel,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] target,
    output logic [4:0]      rd,
    output logic            writes_rd,
    output logic            is_branch,
    output logic            br_invert,
    output logic            illegal
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] i_imm;
    logic [XLEN-1:0] u_imm;
    logic [XLEN-1:0] b_imm;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rd     = instr[11:7];

    // Sign-extended immediates; the signed casts widen to XLEN.
    assign i_imm = XLEN'($signed(instr[31:20]));
    assign u_imm = XLEN'($signed({instr[31:12], 12'b0}));
    assign b_imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));

    // Branch target is formed here so the E stage only has to carry it.
    assign target = pc + b_imm;

    // Opcode/funct decode; anything not recognised collapses to an illegal NOP.
    always_comb begin
        op        = ALU_NOP;
        a_sel     = A_RS1;
        b_sel     = B_RS2;
        imm       = i_imm;
        writes_rd = 1'b0;
        is_branch = 1'b0;
        br_invert = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OPC_OP: begin
                writes_rd = 1'b1;
                case (funct3)
                    F3_ADD_SUB: begin
                        if (funct7 == F7_BASE)     op = ALU_ADD;
                        else if (funct7 == F7_ALT) op = ALU_SUB;
                        else                       illegal = 1'b1;
                    end
                    F3_AND: begin
                        if (funct7 == F7_BASE) op = ALU_AND;
                        else                   illegal = 1'b1;
                    end
                    F3_OR: begin
                        if (funct7 == F7_BASE) op = ALU_OR;
                        else                   illegal = 1'b1;
                    end
                    F3_XOR: begin
                        if (funct7 == F7_BASE) op = ALU_XOR;
                        else                   illegal = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                writes_rd = 1'b1;
                b_sel     = B_IMM;
                case (funct3)
                    F3_ADD_SUB: op = ALU_ADD;
                    F3_AND:     op = ALU_AND;
                    F3_OR:      op = ALU_OR;
                    F3_XOR:     op = ALU_XOR;
                    default:    illegal = 1'b1;
                endcase
            end
            OPC_LUI: begin
                writes_rd = 1'b1;
                op        = ALU_ADDR;
                a_sel     = A_ZERO;
                b_sel     = B_IMM;
                imm       = u_imm;
            end
            OPC_AUIPC: begin
                writes_rd = 1'b1;
                op        = ALU_ADDR;
                a_sel     = A_PC;
                b_sel     = B_IMM;
                imm       = u_imm;
            end
            OPC_BRANCH: begin
                is_branch = 1'b1;
                case (funct3)
                    F3_BEQ:  op = ALU_EQ;
                    F3_BNE: begin
                        op        = ALU_EQ;
                        br_invert = 1'b1;
                    end
                    F3_BLT:  op = ALU_LT;
                    F3_BGE:  op = ALU_GE;
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            op        = ALU_NOP;
            writes_rd = 1'b0;
            is_branch = 1'b0;
            br_invert = 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/resolve controller for a combinational ALU: decodes one instruction per
// cycle, registers A/B/op into the ALU, and one cycle later turns res/zero into
// a writeback pulse, a branch redirect or an illegal-instruction pulse.
// Define ALU_ISSUE_CHECK_EN to add a sticky alu_err output fed by an internal
// reference model of the ALU.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC_OUT = '0
) (
    input  logic            CLK,
    input  logic            RSTa,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic [4:0]      ALU_operation,
    output logic [XLEN-1:0] A,
    output logic [XLEN-1:0] B,
    input  logic [XLEN-1:0] res,
    input  logic            zero,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
`ifdef ALU_ISSUE_CHECK_EN
    output logic            alu_err,
`endif
    output logic            illegal
);

    // Decoder outputs
    alu_op_t         dec_op;
    a_sel_t          dec_a_sel;
    b_sel_t          dec_b_sel;
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] dec_target;
    logic [4:0]      dec_rd;
    logic            dec_writes_rd;
    logic            dec_is_branch;
    logic            dec_br_invert;
    logic            dec_illegal;

    // FSM and E-stage registers
    state_t          state_reg, state_next;
    alu_op_t         e_op_reg;
    logic [XLEN-1:0] a_reg, b_reg;
    logic [XLEN-1:0] a_next, b_next;
    logic [4:0]      e_rd_reg;
    logic            e_writes_reg;
    logic            e_branch_reg;
    logic            e_invert_reg;
    logic            e_illegal_reg;
    logic [XLEN-1:0] e_target_reg;

    // Output-stage registers
    logic            wb_valid_reg;
    logic [4:0]      wb_rd_reg;
    logic [XLEN-1:0] wb_data_reg;
    logic            redirect_valid_reg;
    logic [XLEN-1:0] redirect_pc_reg;
    logic            illegal_reg;

    logic accept;
    logic e_valid;
    logic taken;
    logic load_e;

    alu_decoder #(.XLEN(XLEN)) u_decoder (
        .instr     (instr),
        .pc        (pc),
        .op        (dec_op),
        .a_sel     (dec_a_sel),
        .b_sel     (dec_b_sel),
        .imm       (dec_imm),
        .target    (dec_target),
        .rd        (dec_rd),
        .writes_rd (dec_writes_rd),
        .is_branch (dec_is_branch),
        .br_invert (dec_br_invert),
        .illegal   (dec_illegal)
    );

    assign in_ready = (state_reg != FLUSH);
    assign accept   = in_valid && in_ready;
    assign e_valid  = (state_reg == EXEC);
    // A taken branch in E squashes whatever is accepted alongside it.
    assign taken    = e_valid && e_branch_reg && (zero ^ e_invert_reg);
    assign load_e   = accept && !taken;

    // State register
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic: EXEC while E holds an instruction, FLUSH for the redirect cycle
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = EXEC;
            EXEC: begin
                if (taken)       state_next = FLUSH;
                else if (accept) state_next = EXEC;
                else             state_next = IDLE;
            end
            FLUSH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand selection; illegal instructions travel with zero operands
    always_comb begin
        a_next = rs1_data;
        b_next = rs2_data;
        case (dec_a_sel)
            A_PC:    a_next = pc;
            A_ZERO:  a_next = '0;
            default: a_next = rs1_data;
        endcase
        if (dec_b_sel == B_IMM) b_next = dec_imm;
        if (dec_illegal) begin
            a_next = '0;
            b_next = '0;
        end
    end

    // E-stage register: loaded on accept, otherwise emptied to a NOP
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            e_op_reg      <= ALU_NOP;
            a_reg         <= '0;
            b_reg         <= '0;
            e_rd_reg      <= '0;
            e_writes_reg  <= 1'b0;
            e_branch_reg  <= 1'b0;
            e_invert_reg  <= 1'b0;
            e_illegal_reg <= 1'b0;
            e_target_reg  <= '0;
        end else if (load_e) begin
            e_op_reg      <= dec_op;
            a_reg         <= a_next;
            b_reg         <= b_next;
            e_rd_reg      <= dec_rd;
            e_writes_reg  <= dec_writes_rd;
            e_branch_reg  <= dec_is_branch;
            e_invert_reg  <= dec_br_invert;
            e_illegal_reg <= dec_illegal;
            e_target_reg  <= dec_target;
        end else begin
            e_op_reg      <= ALU_NOP;
            a_reg         <= '0;
            b_reg         <= '0;
            e_rd_reg      <= '0;
            e_writes_reg  <= 1'b0;
            e_branch_reg  <= 1'b0;
            e_invert_reg  <= 1'b0;
            e_illegal_reg <= 1'b0;
            e_target_reg  <= '0;
        end
    end

    // Resolve stage: capture res/zero into single-cycle output pulses
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            wb_valid_reg       <= 1'b0;
            wb_rd_reg          <= '0;
            wb_data_reg        <= '0;
            redirect_valid_reg <= 1'b0;
            redirect_pc_reg    <= RESET_PC_OUT;
            illegal_reg        <= 1'b0;
        end else begin
            wb_valid_reg       <= e_valid && e_writes_reg && (e_rd_reg != 5'd0);
            redirect_valid_reg <= taken;
            illegal_reg        <= e_valid && e_illegal_reg;
            if (e_valid && e_writes_reg && (e_rd_reg != 5'd0)) begin
                wb_rd_reg   <= e_rd_reg;
                wb_data_reg <= res;
            end
            if (taken) redirect_pc_reg <= e_target_reg;
        end
    end

    assign ALU_operation  = e_op_reg;
    assign A              = a_reg;
    assign B              = b_reg;
    assign wb_valid       = wb_valid_reg;
    assign wb_rd          = wb_rd_reg;
    assign wb_data        = wb_data_reg;
    assign redirect_valid = redirect_valid_reg;
    assign redirect_pc    = redirect_pc_reg;
    assign illegal        = illegal_reg;

`ifdef ALU_ISSUE_CHECK_EN
    logic [XLEN-1:0] chk_res;
    logic            chk_zero;
    logic            chk_is_cmp;
    logic            chk_mismatch;
    logic            alu_err_reg;

    // Reference ALU: compares use the zero flag, everything else the result
    always_comb begin
        chk_res    = '0;
        chk_zero   = 1'b0;
        chk_is_cmp = 1'b0;
        case (e_op_reg)
            ALU_ADD, ALU_ADDR: chk_res = a_reg + b_reg;
            ALU_SUB:           chk_res = a_reg - b_reg;
            ALU_AND:           chk_res = a_reg & b_reg;
            ALU_OR:            chk_res = a_reg | b_reg;
            ALU_XOR:           chk_res = a_reg ^ b_reg;
            ALU_LT: begin
                chk_is_cmp = 1'b1;
                chk_zero   = ($signed(a_reg) < $signed(b_reg));
            end
            ALU_GE: begin
                chk_is_cmp = 1'b1;
                chk_zero   = ($signed(a_reg) >= $signed(b_reg));
            end
            ALU_EQ: begin
                chk_is_cmp = 1'b1;
                chk_zero   = (a_reg == b_reg);
            end
            default: chk_res = '0;
        endcase
        chk_mismatch = (e_op_reg != ALU_NOP) &&
                       (chk_is_cmp ? (zero != chk_zero) : (res != chk_res));
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa)             alu_err_reg <= 1'b0;
        else if (chk_mismatch) alu_err_reg <= 1'b1;
    end

    assign alu_err = alu_err_reg;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: table of decode vectors, directed
// multi-cycle sequences and a randomized phase against an instruction-level
// model. Build with ALU_ISSUE_CHECK_EN to also exercise alu_err.
module tb_alu_issue_ctrl;

    localparam int XLEN = 32;

    logic            CLK = 1'b0;
    logic            RSTa = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     instr = '0;
    logic [XLEN-1:0] pc = '0;
    logic [XLEN-1:0] rs1_data = '0;
    logic [XLEN-1:0] rs2_data = '0;
    logic [4:0]      ALU_operation;
    logic [XLEN-1:0] A, B;
    logic [XLEN-1:0] res;
    logic            zero;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            illegal;
`ifdef ALU_ISSUE_CHECK_EN
    logic            alu_err;
`endif
    logic            force_bad = 1'b0;

    always #5 CLK = ~CLK;

    alu_issue_ctrl #(.XLEN(XLEN), .RESET_PC_OUT(32'h0)) dut (
        .CLK            (CLK),
        .RSTa           (RSTa),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .instr          (instr),
        .pc             (pc),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .ALU_operation  (ALU_operation),
        .A              (A),
        .B              (B),
        .res            (res),
        .zero           (zero),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
`ifdef ALU_ISSUE_CHECK_EN
        .alu_err        (alu_err),
`endif
        .illegal        (illegal)
    );

    // The combinational ALU seen by the DUT (force_bad corrupts the result).
    always_comb begin
        res  = '0;
        zero = 1'b0;
        case (ALU_operation)
            5'b00001, 5'b00011: res = A + B;
            5'b00010: res = A - B;
            5'b00100: res = A & B;
            5'b00101: res = A | B;
            5'b01001: res = A ^ B;
            5'b00110: zero = ($signed(A) < $signed(B));
            5'b00111: zero = ($signed(A) >= $signed(B));
            5'b01010: zero = (A == B);
            default: res = '0;
        endcase
        if (force_bad) res = '0;
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int squash_cyc = -1;

    // Expected outputs per cycle, ring-indexed by cycle number.
    bit          exp_wb[8];
    logic [4:0]  exp_rd[8];
    logic [31:0] exp_data[8];
    bit          exp_rdr[8];
    logic [31:0] exp_pc[8];
    bit          exp_ill[8];
    bit          exp_busy[8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) begin
            exp_wb[i] = 0; exp_rd[i] = '0; exp_data[i] = '0;
            exp_rdr[i] = 0; exp_pc[i] = '0; exp_ill[i] = 0; exp_busy[i] = 0;
        end
        squash_cyc = -1;
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd);
        return {imm, 5'd1, f3, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] opc);
        return {imm, rd, opc};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [2:0] f3);
        return {off[12], off[10:5], 5'd2, 5'd1, f3, off[4:1], off[11], 7'b1100011};
    endfunction

    // Instruction-level model: what the instruction means architecturally,
    // and which pulse it must produce two cycles after acceptance.
    task automatic model_accept(input logic [31:0] ins, input logic [31:0] p,
                                input logic [31:0] r1, input logic [31:0] r2);
        int s;
        logic [6:0] opc, f7;
        logic [4:0] rd;
        logic [2:0] f3;
        logic [31:0] imm_i, imm_u, imm_b, val;
        bit legal, isbr, tk;
        if (cyc == squash_cyc) return;
        s = (cyc + 2) & 7;
        opc = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12]; f7 = ins[31:25];
        imm_i = {{20{ins[31]}}, ins[31:20]};
        imm_u = {ins[31:12], 12'b0};
        imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        legal = 1; isbr = 0; tk = 0; val = '0;
        if (opc == 7'h33) begin
            if (f3 == 0 && f7 == 7'h00)      val = r1 + r2;
            else if (f3 == 0 && f7 == 7'h20) val = r1 - r2;
            else if (f3 == 7 && f7 == 7'h00) val = r1 & r2;
            else if (f3 == 6 && f7 == 7'h00) val = r1 | r2;
            else if (f3 == 4 && f7 == 7'h00) val = r1 ^ r2;
            else legal = 0;
        end else if (opc == 7'h13) begin
            if (f3 == 0)      val = r1 + imm_i;
            else if (f3 == 7) val = r1 & imm_i;
            else if (f3 == 6) val = r1 | imm_i;
            else if (f3 == 4) val = r1 ^ imm_i;
            else legal = 0;
        end else if (opc == 7'h37) begin
            val = imm_u;
        end else if (opc == 7'h17) begin
            val = p + imm_u;
        end else if (opc == 7'h63) begin
            isbr = 1;
            if (f3 == 0)      tk = (r1 == r2);
            else if (f3 == 1) tk = (r1 != r2);
            else if (f3 == 4) tk = ($signed(r1) < $signed(r2));
            else if (f3 == 5) tk = ($signed(r1) >= $signed(r2));
            else legal = 0;
        end else begin
            legal = 0;
        end
        if (!legal) begin
            exp_ill[s] = 1;
        end else if (isbr) begin
            if (tk) begin
                exp_rdr[s]  = 1;
                exp_pc[s]   = p + imm_b;
                exp_busy[s] = 1;
                squash_cyc  = cyc + 1;
            end
        end else if (rd != 0) begin
            exp_wb[s]   = 1;
            exp_rd[s]   = rd;
            exp_data[s] = val;
        end
    endtask

    // One clock cycle: drive, check this cycle's outputs, record acceptance.
    task automatic tick(input bit v, input logic [31:0] ins, input logic [31:0] p,
                        input logic [31:0] r1, input logic [31:0] r2);
        int s;
        in_valid = v; instr = ins; pc = p; rs1_data = r1; rs2_data = r2;
        @(negedge CLK);
        s = cyc & 7;
        chk("wb_valid", {31'b0, wb_valid}, {31'b0, exp_wb[s]});
        if (exp_wb[s]) begin
            chk("wb_rd", {27'b0, wb_rd}, {27'b0, exp_rd[s]});
            chk("wb_data", wb_data, exp_data[s]);
        end
        chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, exp_rdr[s]});
        if (exp_rdr[s]) chk("redirect_pc", redirect_pc, exp_pc[s]);
        chk("illegal", {31'b0, illegal}, {31'b0, exp_ill[s]});
        chk("in_ready", {31'b0, in_ready}, {31'b0, !exp_busy[s]});
        exp_wb[s] = 0; exp_rdr[s] = 0; exp_ill[s] = 0; exp_busy[s] = 0;
        if (v && in_ready) begin
            $display("accept cyc=%0d instr=%h pc=%h rs1=%h rs2=%h", cyc, ins, p, r1, r2);
            model_accept(ins, p, r1, r2);
        end
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    typedef struct {
        logic [31:0] ins, p, r1, r2;
        logic [4:0]  op;
        logic [31:0] a, b;
    } vec_t;

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{enc_r(7'h00, 3'd0, 5'd3),  32'h1000, 32'd5,      32'd7,      5'b00001, 32'd5,      32'd7};
        vecs[1]  = '{enc_r(7'h20, 3'd0, 5'd4),  32'h1000, 32'd10,     32'd3,      5'b00010, 32'd10,     32'd3};
        vecs[2]  = '{enc_r(7'h00, 3'd7, 5'd5),  32'h1000, 32'hF0F0,   32'hFF00,   5'b00100, 32'hF0F0,   32'hFF00};
        vecs[3]  = '{enc_r(7'h00, 3'd6, 5'd6),  32'h1000, 32'hF0F0,   32'hFF00,   5'b00101, 32'hF0F0,   32'hFF00};
        vecs[4]  = '{enc_r(7'h00, 3'd4, 5'd7),  32'h1000, 32'hF0F0,   32'hFF00,   5'b01001, 32'hF0F0,   32'hFF00};
        vecs[5]  = '{enc_i(12'hFFF, 3'd0, 5'd8),  32'h1000, 32'h20,   32'h99,     5'b00001, 32'h20,     32'hFFFF_FFFF};
        vecs[6]  = '{enc_i(12'h0F0, 3'd7, 5'd9),  32'h1000, 32'hABCD, 32'h99,     5'b00100, 32'hABCD,   32'h0F0};
        vecs[7]  = '{enc_i(12'h800, 3'd6, 5'd10), 32'h1000, 32'h1,    32'h99,     5'b00101, 32'h1,      32'hFFFF_F800};
        vecs[8]  = '{enc_i(12'h555, 3'd4, 5'd11), 32'h1000, 32'hAAA,  32'h99,     5'b01001, 32'hAAA,    32'h555};
        vecs[9]  = '{enc_u(20'h12345, 5'd12, 7'h37), 32'h1000, 32'h77, 32'h99,    5'b00011, 32'h0,      32'h1234_5000};
        vecs[10] = '{enc_u(20'h00001, 5'd13, 7'h17), 32'h1000, 32'h77, 32'h99,    5'b00011, 32'h1000,   32'h1000};
        vecs[11] = '{enc_b(13'd8, 3'd0),     32'h1000, 32'd9,  32'd8,  5'b01010, 32'd9, 32'd8};
        vecs[12] = '{enc_b(13'd8, 3'd1),     32'h1000, 32'd9,  32'd8,  5'b01010, 32'd9, 32'd8};
        vecs[13] = '{enc_b(13'h1FFC, 3'd4),  32'h1000, 32'd1,  32'd2,  5'b00110, 32'd1, 32'd2};
        vecs[14] = '{enc_b(13'd8, 3'd5),     32'h1000, 32'd1,  32'd2,  5'b00111, 32'd1, 32'd2};
        vecs[15] = '{32'h0000_007F,          32'h1000, 32'd1,  32'd2,  5'b00000, 32'd0, 32'd0};

        clear_model();

        // Reset values
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_op", {27'b0, ALU_operation}, 32'h0);
        chk("rst_a", A, 32'h0);
        chk("rst_b", B, 32'h0);
        chk("rst_wb_valid", {31'b0, wb_valid}, 32'h0);
        chk("rst_wb_rd", {27'b0, wb_rd}, 32'h0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_redirect_valid", {31'b0, redirect_valid}, 32'h0);
        chk("rst_redirect_pc", redirect_pc, 32'h0);
        chk("rst_illegal", {31'b0, illegal}, 32'h0);
        RSTa = 1'b1;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'h1);

        // Decode table: ALU_operation/A/B one cycle after acceptance
        for (int i = 0; i < 16; i++) begin
            tick(1, vecs[i].ins, vecs[i].p, vecs[i].r1, vecs[i].r2);
            chk($sformatf("vec%0d_op", i), {27'b0, ALU_operation}, {27'b0, vecs[i].op});
            chk($sformatf("vec%0d_a", i), A, vecs[i].a);
            chk($sformatf("vec%0d_b", i), B, vecs[i].b);
            idle(2);
        end

        // Taken beq squashes the younger addi and stalls for one cycle
        tick(1, enc_b(13'd16, 3'd0), 32'h100, 32'd9, 32'd9);
        tick(1, enc_i(12'd1, 3'd0, 5'd5), 32'h104, 32'd1, 32'd0);
        chk("beq_redirect_valid", {31'b0, redirect_valid}, 32'h1);
        chk("beq_redirect_pc", redirect_pc, 32'h110);
        chk("beq_in_ready", {31'b0, in_ready}, 32'h0);
        chk("beq_flush_op", {27'b0, ALU_operation}, 32'h0);
        tick(1, enc_i(12'd1, 3'd0, 5'd6), 32'h108, 32'd1, 32'd0);
        idle(3);

        // Not-taken bne followed back-to-back by an add
        tick(1, enc_b(13'd16, 3'd1), 32'h200, 32'd4, 32'd4);
        tick(1, enc_r(7'h00, 3'd0, 5'd8), 32'h204, 32'd1, 32'd2);
        chk("bne_next_op", {27'b0, ALU_operation}, 32'h1);
        idle(1);
        chk("bne_no_redirect", {31'b0, redirect_valid}, 32'h0);
        idle(2);

        // Three back-to-back addi, the last targeting x0
        tick(1, enc_i(12'd1, 3'd0, 5'd1),     32'h300, 32'd10, 32'd0);
        tick(1, enc_i(12'hFFF, 3'd0, 5'd2),   32'h304, 32'd10, 32'd0);
        tick(1, enc_i(12'd5, 3'd0, 5'd0),     32'h308, 32'd10, 32'd0);
        chk("addi_x0_op", {27'b0, ALU_operation}, 32'h1);
        idle(3);
        chk("stream_end_op", {27'b0, ALU_operation}, 32'h0);

        // Illegal opcode pulses once (model checks N+2 and the cycle after)
        tick(1, 32'h0000_007F, 32'h400, 32'd0, 32'd0);
        idle(3);

        // Reset while a taken blt sits in E
        tick(1, enc_b(13'd8, 3'd4), 32'h500, 32'd1, 32'd2);
        chk("blt_in_exec_op", {27'b0, ALU_operation}, 32'h6);
        #2;
        RSTa = 1'b0;
        #1;
        chk("mid_rst_op", {27'b0, ALU_operation}, 32'h0);
        chk("mid_rst_a", A, 32'h0);
        chk("mid_rst_b", B, 32'h0);
        chk("mid_rst_wb_valid", {31'b0, wb_valid}, 32'h0);
        chk("mid_rst_redirect_valid", {31'b0, redirect_valid}, 32'h0);
        chk("mid_rst_redirect_pc", redirect_pc, 32'h0);
        chk("mid_rst_illegal", {31'b0, illegal}, 32'h0);
        @(posedge CLK);
        #1;
        RSTa = 1'b1;
        cyc++;
        clear_model();
        idle(4);

        // Randomized stream against the model
        for (int n = 0; n < 600; n++) begin
            logic [31:0] ins, r1, r2, p;
            logic [4:0] rd;
            logic [2:0] f3;
            bit v;
            v  = ($urandom_range(0, 9) < 7);
            rd = 5'($urandom_range(0, 31));
            r1 = pick();
            r2 = pick();
            p  = $urandom() & 32'hFFFF_FFFC;
            case ($urandom_range(0, 13))
                0:  ins = enc_r(7'h00, 3'd0, rd);
                1:  ins = enc_r(7'h20, 3'd0, rd);
                2:  ins = enc_r(7'h00, 3'd7, rd);
                3:  ins = enc_r(7'h00, 3'd6, rd);
                4:  ins = enc_r(($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, 3'd4, rd);
                5:  ins = enc_i(12'($urandom()), 3'd0, rd);
                6:  ins = enc_i(12'($urandom()), 3'd7, rd);
                7:  ins = enc_i(12'($urandom()), 3'd6, rd);
                8:  ins = enc_i(12'($urandom()), 3'($urandom_range(0, 7)), rd);
                9:  ins = enc_u(20'($urandom()), rd, 7'h37);
                10: ins = enc_u(20'($urandom()), rd, 7'h17);
                11, 12: begin
                    f3 = 3'($urandom_range(0, 7));
                    if ($urandom_range(0, 1) != 0) r2 = r1;
                    ins = enc_b(13'($urandom()) & 13'h1FFE, f3);
                end
                default: ins = ($urandom() & 32'hFFFF_FF80) | 32'h7F;
            endcase
            tick(v, ins, p, r1, r2);
        end
        idle(4);

`ifdef ALU_ISSUE_CHECK_EN
        // Corrupted ALU result on add 2+2 sets the sticky alu_err
        chk("alu_err_clean", {31'b0, alu_err}, 32'h0);
        force_bad = 1'b1;
        tick(1, enc_r(7'h00, 3'd0, 5'd3), 32'h600, 32'd2, 32'd2);
        exp_data[(cyc + 1) & 7] = 32'h0;
        tick(0, 32'h0, 32'h0, 32'h0, 32'h0);
        force_bad = 1'b0;
        idle(1);
        chk("alu_err_set", {31'b0, alu_err}, 32'h1);
        idle(5);
        chk("alu_err_sticky", {31'b0, alu_err}, 32'h1);
        RSTa = 1'b0;
        #1;
        chk("alu_err_rst", {31'b0, alu_err}, 32'h0);
        @(posedge CLK);
        #1;
        RSTa = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net: never run away
    initial begin
        #500000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
